alu_multiciclo: RTL and testbench
=================================

Name: alu_multiciclo

Overview:
- Multi-cycle, handshaked arithmetic unit for the pipeline's execute stage.
- Uses the same operation encoding as the combinational ALU: 000 add, 001 sub, 010 mul, 011 div, 100 rem, 101-111 add.
- Performs mul/div/rem iteratively instead of with single-cycle multiplier and divider arrays.
- The hazard unit stalls the pipeline while the unit is busy. The result, plus a zero flag, is returned over a valid/ready interface.

Parameters:
WIDTH, 32, operand and result width in bits.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  request valid; A, B, sel are valid while high.
in_ready  output  1  unit can accept a request.
A  input  WIDTH  operand A, unsigned.
B  input  WIDTH  operand B, unsigned.
sel  input  3  operation code, as listed in Overview.
out_valid  output  1  C and flagZ hold a result.
out_ready  input  1  consumer accepts the result.
C  output  WIDTH  result.
flagZ  output  1  high when C == 0.
busy  output  1  high in CALC or DONE.

Behaviour:
- Reset, asynchronous and active-high: state=IDLE, in_ready=1, out_valid=0, C=0, flagZ=0, busy=0, iteration counter=0. Reset asserted mid-operation aborts the operation. No result is produced and no partial state survives.
- FSM states: IDLE, CALC, DONE. in_ready = (state==IDLE).
- Accept: the cycle where in_valid & in_ready. A, B and sel are latched into internal registers. Input changes after accept are ignored.
- From IDLE on accept:
  - add (000, 101-111) and sub (001): result computed from the latched operands, wrapping mod 2^WIDTH, e.g. 0 - 1 = all ones. Next state DONE.
  - div (011) or rem (100) with B == 0: next state DONE. div gives C = all ones; rem gives C = A.
  - mul (010), div/rem with B != 0: next state CALC, counter=0.
- CALC, mul: shift-add, one multiplier bit per cycle, WIDTH cycles. C = low WIDTH bits of A*B; overflow is silently discarded.
- CALC, div/rem: restoring division, one quotient bit per cycle, WIDTH cycles. div gives C = floor(A/B); rem gives C = A mod B.
- CALC exit: after iteration WIDTH-1 (counter==WIDTH-1), next state DONE.
- DONE:
  - out_valid=1. C and flagZ are registered and held stable until handshake.
  - On out_valid & out_ready, next state is IDLE and out_valid drops the following cycle.
  - A new request can be accepted no earlier than the cycle after the handshake; there is no same-cycle turnaround.
- Latency, accept edge to first out_valid cycle: 1 cycle for add/sub/div-by-zero/rem-by-zero; WIDTH+1 cycles (33 at default) for mul/div/rem.
- flagZ is registered together with C and equals (C==0).
- Backpressure: if out_ready stays low, the unit stays in DONE indefinitely with outputs unchanged.
- in_valid asserted in CALC or DONE is not accepted. The requester must hold the request until in_ready.
- Iterative datapath: one adder/subtractor of WIDTH+1 bits, shift registers for the partial product and partial remainder, and a log2(WIDTH)+1-bit counter.

Test Plan:
- Reset during operation: start mul, assert rst at cycle 10 -> out_valid=0, in_ready=1, C=0 immediately; no result later.
- A=7, B=5, sel=001, out_ready=1 -> out_valid one cycle after accept, C=2, flagZ=0. Then A=5, B=5, sel=001 -> C=0, flagZ=1.
- A=0xFFFF_FFFF, B=2, sel=010 -> out_valid at accept+33, C=0xFFFF_FFFE. A=0x10000, B=0x10000 -> C=0, flagZ=1.
- A=100, B=7: sel=011 -> C=14; sel=100 -> C=2; each result at accept+33.
- A=100, B=0: sel=011 -> C=0xFFFF_FFFF; sel=100 -> C=100; each result at accept+1.
- Backpressure: A=9, B=4, sel=000 -> C=13; hold out_ready=0 for 5 cycles -> out_valid and C=13 stable, in_ready=0. Raise out_ready -> out_valid low next cycle, in_ready high. sel=110 with A=3, B=4 -> C=7.

Source files
------------

// File: rtl/alu_multiciclo.sv
// Multi-cycle execute-stage ALU: add/sub in one step, mul (shift-add) and
// div/rem (restoring) iterated one bit per cycle behind a valid/ready handshake.
module alu_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             flagZ,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_REM = 3'b100
  } op_e;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] acc;    // partial product (mul) or partial remainder (div/rem)
  logic [WIDTH-1:0] shreg;  // multiplier bits (mul) or dividend shifting into quotient (div/rem)
  logic [WIDTH-1:0] opnd;   // multiplicand (mul) or divisor (div/rem)
  logic             is_mul;
  logic             is_rem;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   x;
  logic [WIDTH:0]   y;
  logic [WIDTH:0]   sum;
  logic             qbit;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] final_c;
  logic [WIDTH-1:0] quick_c;
  logic             starts_calc;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // One shared WIDTH+1 adder/subtractor: MSB-first shift-add for mul,
  // trial subtraction with restore for div/rem.
  always_comb begin
    x        = '0;
    y        = '0;
    sum      = '0;
    qbit     = 1'b0;
    acc_next = '0;
    final_c  = '0;
    if (is_mul) begin
      x        = {1'b0, acc[WIDTH-2:0], 1'b0};
      y        = shreg[WIDTH-1] ? {1'b0, opnd} : '0;
      sum      = x + y;
      acc_next = sum[WIDTH-1:0];
      final_c  = acc_next;
    end else begin
      x        = {acc, shreg[WIDTH-1]};
      y        = {1'b0, opnd};
      sum      = x - y;
      qbit     = ~sum[WIDTH];
      acc_next = qbit ? sum[WIDTH-1:0] : x[WIDTH-1:0];
      final_c  = is_rem ? acc_next : {shreg[WIDTH-2:0], qbit};
    end
  end

  always_comb begin
    quick_c     = A + B;
    starts_calc = 1'b0;
    case (sel)
      OP_SUB: quick_c = A - B;
      OP_MUL: starts_calc = 1'b1;
      OP_DIV: begin
        quick_c     = '1;
        starts_calc = (B != '0);
      end
      OP_REM: begin
        quick_c     = A;
        starts_calc = (B != '0);
      end
      default: quick_c = A + B;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      C         <= '0;
      flagZ     <= 1'b0;
      acc       <= '0;
      shreg     <= '0;
      opnd      <= '0;
      is_mul    <= 1'b0;
      is_rem    <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (starts_calc) begin
              is_mul <= (sel == OP_MUL);
              is_rem <= (sel == OP_REM);
              acc    <= '0;
              shreg  <= (sel == OP_MUL) ? B : A;
              opnd   <= (sel == OP_MUL) ? A : B;
              cnt    <= '0;
              state  <= CALC;
            end else begin
              C         <= quick_c;
              flagZ     <= (quick_c == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        CALC: begin
          acc   <= acc_next;
          shreg <= {shreg[WIDTH-2:0], is_mul ? 1'b0 : qbit};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            C         <= final_c;
            flagZ     <= (final_c == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo: directed table, random ops against
// an arithmetic reference model, backpressure and mid-operation reset.
module tb_alu_multiciclo;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] C;
  logic         flagZ;
  logic         busy;

  int checks = 0;
  int errors = 0;

  alu_multiciclo #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .flagZ(flagZ), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] exp_c;
  } vec_t;

  vec_t vt[14];

  function automatic logic [W-1:0] model_c(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      3'd1:    return a - b;
      3'd2:    return p[W-1:0];
      3'd3:    return (b == 0) ? {W{1'b1}} : a / b;
      3'd4:    return (b == 0) ? a : a % b;
      default: return a + b;
    endcase
  endfunction

  function automatic int model_lat(input logic [W-1:0] b, input logic [2:0] op);
    if (op == 3'd2) return W + 1;
    if ((op == 3'd3 || op == 3'd4) && b != 0) return W + 1;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    A = a;
    B = b;
    sel = op;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    sel = 3'($urandom);
  endtask

  task automatic wait_result(input string name, input logic [W-1:0] exp_c, input int exp_lat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_C"}, 64'(C), 64'(exp_c));
    chk({name, "_flagZ"}, 64'(flagZ), 64'(exp_c == 0));
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_hs_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_hs_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [2:0] op, input logic [W-1:0] exp_c);
    start_op(a, b, op);
    wait_result(name, exp_c, model_lat(b, op));
    handshake(name);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;
    int           late;

    vt[0]  = '{32'd7,          32'd5,          3'd1, 32'd2};
    vt[1]  = '{32'd5,          32'd5,          3'd1, 32'd0};
    vt[2]  = '{32'hFFFF_FFFF,  32'd2,          3'd2, 32'hFFFF_FFFE};
    vt[3]  = '{32'h0001_0000,  32'h0001_0000,  3'd2, 32'd0};
    vt[4]  = '{32'd100,        32'd7,          3'd3, 32'd14};
    vt[5]  = '{32'd100,        32'd7,          3'd4, 32'd2};
    vt[6]  = '{32'd100,        32'd0,          3'd3, 32'hFFFF_FFFF};
    vt[7]  = '{32'd100,        32'd0,          3'd4, 32'd100};
    vt[8]  = '{32'd0,          32'd1,          3'd1, 32'hFFFF_FFFF};
    vt[9]  = '{32'd3,          32'd4,          3'd6, 32'd7};
    vt[10] = '{32'd5,          32'd3,          3'd7, 32'd8};
    vt[11] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  3'd3, 32'd1};
    vt[12] = '{32'd5,          32'd9,          3'd4, 32'd5};
    vt[13] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  3'd2, 32'd1};

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; sel = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_C", 64'(C), 64'd0);
    chk("rst_flagZ", 64'(flagZ), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      run($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].op, vt[i].exp_c);

    for (int i = 0; i < 40; i++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? '0 :
            ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 1000)) : W'($urandom);
      rop = 3'($urandom_range(0, 7));
      run($sformatf("rnd%0d_op%0d", i, rop), ra, rb, rop, model_c(ra, rb, rop));
    end

    // Backpressure: result held while out_ready low, new requests ignored.
    out_ready = 1'b0;
    start_op(32'd9, 32'd4, 3'd0);
    wait_result("bp", 32'd13, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; A = 32'd1; B = 32'd1; sel = 3'd1;
      @(posedge clk);
      #1;
      chk($sformatf("bp_valid%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("bp_C%0d", i), 64'(C), 64'd13);
      chk($sformatf("bp_in_ready%0d", i), 64'(in_ready), 64'd0);
      chk($sformatf("bp_busy%0d", i), 64'(busy), 64'd1);
    end
    in_valid = 1'b0;
    handshake("bp");
    run("bp_next", 32'd3, 32'd4, 3'd6, 32'd7);

    // Reset mid-multiply: aborted, no late result.
    start_op(32'd12345, 32'd678, 3'd2);
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_C", 64'(C), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    late = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) late++;
    end
    chk("arst_no_result", 64'(late), 64'd0);

    run("post_rst_div", 32'd1000, 32'd33, 3'd3, 32'd30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
